conv_window_buffer: RTL and testbench

//   Upstream feeder for the 3x3 convolution stage. Accepts a raster-order stream of fixed-point pixels,

---
 rtl/conv_window_buffer.sv | 140 ++++++++++++++
 tb/tb_conv_window_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// Raster-stream to 3x3 window feeder for the conv stage: two line buffers plus a
// 3x3 shift window, emitting one packed window per unpadded output position.

module conv_window_line_buf #(
  parameter int PW    = 13,
  parameter int DEPTH = 28,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [PW-1:0] wr_data,
  output logic [PW-1:0] rd_data
);
  // No reset on the storage: stale contents are masked by the valid gating.
  logic [PW-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end
endmodule

module conv_window_row #(
  parameter int PW = 13
) (
  input  logic               i_clk,
  input  logic               kernel_reset,
  input  logic               shift_en,
  input  logic [PW-1:0]      din,
  output logic [2:0][PW-1:0] taps
);
  // taps[0] is the oldest (leftmost) column, taps[2] the newest.
  always_ff @(posedge i_clk or posedge kernel_reset) begin
    if (kernel_reset) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {din, taps[2], taps[1]};
    end
  end
endmodule

module conv_window_buffer #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 28,
  parameter int IMG_HEIGHT       = 28,
  localparam int PW              = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic            i_clk,
  input  logic            kernel_reset,
  input  logic [PW-1:0]   i_pixel_data,
  input  logic            i_pixel_data_valid,
  output logic [9*PW-1:0] o_window_data,
  output logic            o_window_valid,
  output logic            o_frame_done
);
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int STAGES = 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col, last_row;

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge i_clk or posedge kernel_reset) begin
    if (kernel_reset) begin
      col <= '0;
      row <= '0;
    end else if (i_pixel_data_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer chain: lb[0] holds row r-1, lb[1] holds row r-2.
  logic [1:0][PW-1:0] lb_rd, lb_wr;
  logic               lb_we;

  assign lb_we    = i_pixel_data_valid & ~kernel_reset;
  assign lb_wr[0] = i_pixel_data;
  assign lb_wr[1] = lb_rd[0];

  for (genvar g = 0; g < 2; g++) begin : g_lb
    conv_window_line_buf #(.PW(PW), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb (
      .i_clk   (i_clk),
      .wr_en   (lb_we),
      .addr    (col),
      .wr_data (lb_wr[g]),
      .rd_data (lb_rd[g])
    );
  end

  // Incoming column, top to bottom: row r-2, row r-1, row r.
  logic [2:0][PW-1:0]      new_col;
  logic [2:0][2:0][PW-1:0] win;

  assign new_col[0] = lb_rd[1];
  assign new_col[1] = lb_rd[0];
  assign new_col[2] = i_pixel_data;

  for (genvar g = 0; g < 3; g++) begin : g_row
    conv_window_row #(.PW(PW)) u_row (
      .i_clk        (i_clk),
      .kernel_reset (kernel_reset),
      .shift_en     (i_pixel_data_valid),
      .din          (new_col[g]),
      .taps         (win[g])
    );
  end

  // win[r][c] lands at slot r*3+c, giving row-major packing with slot 0 top-left.
  assign o_window_data = win;

  logic [STAGES:0] vld_pipe, fd_pipe;

  assign vld_pipe[0] = i_pixel_data_valid && (row >= RW'(2)) && (col >= CW'(2));
  assign fd_pipe[0]  = i_pixel_data_valid && last_row && last_col;

  always_ff @(posedge i_clk or posedge kernel_reset) begin
    if (kernel_reset) begin
      vld_pipe[STAGES:1] <= '0;
      fd_pipe[STAGES:1]  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      fd_pipe[STAGES:1]  <= fd_pipe[STAGES-1:0];
    end
  end

  assign o_window_valid = vld_pipe[STAGES];
  assign o_frame_done   = fd_pipe[STAGES];
endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on a 5x4 image with a window scoreboard.

module tb_conv_window_buffer;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 13;

  logic            clk = 1'b0;
  logic            kernel_reset;
  logic [PW-1:0]   pix;
  logic            pix_vld;
  logic [9*PW-1:0] win_data;
  logic            win_vld;
  logic            frame_done;

  conv_window_buffer #(
    .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .i_clk              (clk),
    .kernel_reset       (kernel_reset),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_vld),
    .o_window_data      (win_data),
    .o_window_valid     (win_vld),
    .o_frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*PW-1:0] data;
    logic            fd;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   strobes  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window straight from the image definition: pixel(r,c) = base + r*W + c.
  function automatic logic [9*PW-1:0] exp_win(input int r, input int c, input int base);
    logic [9*PW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*PW +: PW] = PW'(base + (r-2+i)*W + (c-2+j));
    return w;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (win_vld) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("win_data", 128'(win_data), 128'(e.data));
        chk("frame_done", 128'(frame_done), 128'(e.fd));
        chk("latency", 128'(cyc), 128'(e.cyc + 1));
        strobes++;
      end
    end else if (frame_done) begin
      chk("fd_without_valid", 128'(frame_done), 128'(0));
    end
  end

  task automatic send(input int r, input int c, input int base);
    exp_t e;
    @(posedge clk); #1;
    pix     = PW'(base + r*W + c);
    pix_vld = 1'b1;
    if (r >= 2 && c >= 2) begin
      e.data = exp_win(r, c, base);
      e.fd   = (r == H-1 && c == W-1);
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pix_vld = 1'b0;
      pix     = PW'($urandom);
    end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c, base);
        if (gaps) idle($urandom_range(1, 3));
      end
  endtask

  task automatic drain(input string tag, input int n_exp);
    idle(4);
    chk({tag, "_drained"}, 128'(sb.size()), 128'(0));
    chk({tag, "_strobes"}, 128'(strobes), 128'(n_exp));
    strobes = 0;
  endtask

  initial begin
    kernel_reset = 1'b1;
    pix          = '0;
    pix_vld      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 128'(win_data), 128'(0));
    chk("rst_valid", 128'(win_vld), 128'(0));
    chk("rst_fd", 128'(frame_done), 128'(0));
    kernel_reset = 1'b0;

    // Back-to-back frame; covers first window and row-wrap windows.
    send_frame(0, 1'b0);
    drain("b2b", 6);
    chk("hold_data", 128'(win_data), 128'(exp_win(H-1, W-1, 0)));
    chk("hold_valid", 128'(win_vld), 128'(0));

    // Random gaps between pixels.
    send_frame(0, 1'b1);
    drain("gaps", 6);

    // Two frames back-to-back with an offset on the second.
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain("two_frames", 12);

    // Reset partway into row 2, with valid held high during reset.
    for (int c = 0; c < W; c++) send(0, c, 50);
    for (int c = 0; c < W; c++) send(1, c, 50);
    send(2, 0, 50);
    send(2, 1, 50);
    @(posedge clk); #1;
    kernel_reset = 1'b1;
    pix          = PW'(13'h1abc);
    #1;
    chk("mid_rst_data", 128'(win_data), 128'(0));
    chk("mid_rst_valid", 128'(win_vld), 128'(0));
    chk("mid_rst_fd", 128'(frame_done), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_data_held", 128'(win_data), 128'(0));
    chk("mid_rst_valid_held", 128'(win_vld), 128'(0));
    pix_vld      = 1'b0;
    kernel_reset = 1'b0;
    idle(2);
    send_frame(200, 1'b1);
    drain("after_rst", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
